// File: rtl/tracker_scan_fsm_pkg.sv
// ============================================================================
// Module : tracker_scan_fsm_pkg
// Brief  : State codes and shared helpers for the light-tracker scan controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tracker_scan_fsm_pkg;

   localparam int unsigned STAT_W = 3;
   localparam int unsigned IDLE_W = 16;

   // Codes are visible on the status port, so keep them stable.
   typedef enum logic [STAT_W-1:0] {
      ST_MAN     = 3'd0,
      ST_H_HOME  = 3'd1,
      ST_H_SWEEP = 3'd2,
      ST_H_RET   = 3'd3,
      ST_V_HOME  = 3'd4,
      ST_V_SWEEP = 3'd5,
      ST_V_RET   = 3'd6
   } state_e;

   function automatic logic jog_only(input logic want, input logic other);
      return want & ~other;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tracker_scan_fsm_step_tick.sv
// ============================================================================
// Module : tracker_scan_fsm_step_tick
// Brief  : Free-running STEP_DIV divider; tick_o high in the last count cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tracker_scan_fsm_step_tick #(
   parameter int unsigned STEP_DIV = 100000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   output logic tick_o
);

   localparam int unsigned      CNT_W    = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_ONE;
      end
   end

   assign tick_o = (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/tracker_scan_fsm.sv
// ============================================================================
// Module : tracker_scan_fsm
// Brief  : Two-axis light tracker: manual jog plus home/sweep/return scan.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tracker_scan_fsm
   import tracker_scan_fsm_pkg::*;
#(
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned POS_W       = 8,
   parameter int unsigned H_STEPS     = 180,
   parameter int unsigned V_STEPS     = 90,
   parameter int unsigned STEP_DIV    = 100000,
   parameter int unsigned AUTO_PERIOD = 0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              btn_l_i,
   input  logic              btn_r_i,
   input  logic              btn_u_i,
   input  logic              btn_d_i,
   input  logic              btn_c_i,
   input  logic [DATA_W-1:0] light_i,
   input  logic              light_vld_i,
   output logic              servo_l_o,
   output logic              servo_r_o,
   output logic              servo_u_o,
   output logic              servo_d_o,
   output logic [POS_W-1:0]  pos_h_o,
   output logic [POS_W-1:0]  pos_v_o,
   output logic [POS_W-1:0]  max_h_o,
   output logic [POS_W-1:0]  max_v_o,
   output logic [DATA_W-1:0] max_val_o,
   output logic [2:0]        stat_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [POS_W-1:0] H_LAST  = POS_W'(H_STEPS - 1);
   localparam logic [POS_W-1:0] V_LAST  = POS_W'(V_STEPS - 1);
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   state_e              state_q;
   logic [POS_W-1:0]    pos_h_q, pos_v_q, best_h_q, best_v_q, max_h_q, max_v_q;
   logic [DATA_W-1:0]   sample_q, best_q, max_val_q;
   logic                servo_l_q, servo_r_q, servo_u_q, servo_d_q, done_q;
   logic                tick, any_btn, auto_fire;

   tracker_scan_fsm_step_tick #(
      .STEP_DIV (STEP_DIV)
   ) u_step_tick (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .tick_o  (tick)
   );

   assign any_btn = btn_l_i | btn_r_i | btn_u_i | btn_d_i | btn_c_i;

   generate
      if (AUTO_PERIOD != 0) begin : g_auto
         localparam logic [IDLE_W-1:0] AUTO_LAST = IDLE_W'(AUTO_PERIOD - 1);
         localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
         logic [IDLE_W-1:0] idle_q;

         // Counts idle ticks only while in manual mode; any button restarts it.
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               idle_q <= '0;
            end else if (state_q != ST_MAN || any_btn) begin
               idle_q <= '0;
            end else if (tick) begin
               idle_q <= (idle_q == AUTO_LAST) ? '0 : idle_q + IDLE_ONE;
            end
         end

         assign auto_fire = (state_q == ST_MAN) && !any_btn && tick && (idle_q == AUTO_LAST);
      end else begin : g_no_auto
         assign auto_fire = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sample_q <= '0;
      end else if (light_vld_i) begin
         sample_q <= light_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_MAN;
         pos_h_q   <= '0;
         pos_v_q   <= '0;
         best_q    <= '0;
         best_h_q  <= '0;
         best_v_q  <= '0;
         max_h_q   <= '0;
         max_v_q   <= '0;
         max_val_q <= '0;
         servo_l_q <= 1'b0;
         servo_r_q <= 1'b0;
         servo_u_q <= 1'b0;
         servo_d_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         servo_l_q <= 1'b0;
         servo_r_q <= 1'b0;
         servo_u_q <= 1'b0;
         servo_d_q <= 1'b0;
         done_q    <= 1'b0;
         if (state_q == ST_MAN) begin
            if (btn_c_i || auto_fire) begin
               state_q <= ST_H_HOME;
            end else if (tick) begin
               if (jog_only(btn_l_i, btn_r_i) && pos_h_q != '0) begin
                  servo_l_q <= 1'b1;
                  pos_h_q   <= pos_h_q - POS_ONE;
               end
               if (jog_only(btn_r_i, btn_l_i) && pos_h_q != H_LAST) begin
                  servo_r_q <= 1'b1;
                  pos_h_q   <= pos_h_q + POS_ONE;
               end
               if (jog_only(btn_d_i, btn_u_i) && pos_v_q != '0) begin
                  servo_d_q <= 1'b1;
                  pos_v_q   <= pos_v_q - POS_ONE;
               end
               if (jog_only(btn_u_i, btn_d_i) && pos_v_q != V_LAST) begin
                  servo_u_q <= 1'b1;
                  pos_v_q   <= pos_v_q + POS_ONE;
               end
            end
         end else if (btn_c_i) begin
            // Abort wins over any step due this cycle; position and results stay put.
            state_q <= ST_MAN;
         end else if (tick) begin
            case (state_q)
               ST_H_HOME: begin
                  if (pos_h_q != '0) begin
                     servo_l_q <= 1'b1;
                     pos_h_q   <= pos_h_q - POS_ONE;
                  end else begin
                     state_q  <= ST_H_SWEEP;
                     best_q   <= '0;
                     best_h_q <= '0;
                  end
               end
               ST_H_SWEEP: begin
                  if (sample_q > best_q) begin
                     best_q   <= sample_q;
                     best_h_q <= pos_h_q;
                  end
                  if (pos_h_q == H_LAST) begin
                     state_q <= ST_H_RET;
                  end else begin
                     servo_r_q <= 1'b1;
                     pos_h_q   <= pos_h_q + POS_ONE;
                  end
               end
               ST_H_RET: begin
                  if (pos_h_q != best_h_q) begin
                     servo_l_q <= 1'b1;
                     pos_h_q   <= pos_h_q - POS_ONE;
                  end else begin
                     state_q <= ST_V_HOME;
                  end
               end
               ST_V_HOME: begin
                  if (pos_v_q != '0) begin
                     servo_d_q <= 1'b1;
                     pos_v_q   <= pos_v_q - POS_ONE;
                  end else begin
                     state_q  <= ST_V_SWEEP;
                     best_q   <= '0;
                     best_v_q <= '0;
                  end
               end
               ST_V_SWEEP: begin
                  if (sample_q > best_q) begin
                     best_q   <= sample_q;
                     best_v_q <= pos_v_q;
                  end
                  if (pos_v_q == V_LAST) begin
                     state_q <= ST_V_RET;
                  end else begin
                     servo_u_q <= 1'b1;
                     pos_v_q   <= pos_v_q + POS_ONE;
                  end
               end
               ST_V_RET: begin
                  if (pos_v_q != best_v_q) begin
                     servo_d_q <= 1'b1;
                     pos_v_q   <= pos_v_q - POS_ONE;
                  end else begin
                     state_q   <= ST_MAN;
                     done_q    <= 1'b1;
                     max_h_q   <= best_h_q;
                     max_v_q   <= best_v_q;
                     max_val_q <= best_q;
                  end
               end
               default: state_q <= ST_MAN;
            endcase
         end
      end
   end

   assign servo_l_o = servo_l_q;
   assign servo_r_o = servo_r_q;
   assign servo_u_o = servo_u_q;
   assign servo_d_o = servo_d_q;
   assign pos_h_o   = pos_h_q;
   assign pos_v_o   = pos_v_q;
   assign max_h_o   = max_h_q;
   assign max_v_o   = max_v_q;
   assign max_val_o = max_val_q;
   assign stat_o    = state_q;
   assign busy_o    = (state_q != ST_MAN);
   assign done_o    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tracker_scan_fsm.sv
// ============================================================================
// Module : tb_tracker_scan_fsm
// Brief  : Self-checking bench: jog vector table, strobe scoreboard, scan cases.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tracker_scan_fsm;

   localparam int DW = 8;
   localparam int PW = 8;
   localparam int HS = 8;
   localparam int VS = 4;
   localparam int SD = 4;

   localparam logic [3:0] S_L = 4'b1000;
   localparam logic [3:0] S_R = 4'b0100;
   localparam logic [3:0] S_U = 4'b0010;
   localparam logic [3:0] S_D = 4'b0001;
   localparam logic [3:0] S_0 = 4'b0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, bl, br, bu, bd, bc, lvld, flat_mode;
   logic [DW-1:0] light;
   logic          sl, sr, su, sdn, busy, done;
   logic [PW-1:0] ph, pv, mh, mv;
   logic [DW-1:0] mval;
   logic [2:0]    stat;

   logic          a_rst_n, a_bu;
   logic          a_sl, a_sr, a_su, a_sd, a_busy, a_done;
   logic [PW-1:0] a_ph, a_pv, a_mh, a_mv;
   logic [DW-1:0] a_mval;
   logic [2:0]    a_stat;

   function automatic logic [DW-1:0] light_f(input int h, input int v, input logic flat);
      if (flat) return 8'd50;
      if (h == 5 && v == 2) return 8'd200;
      if (h == 5) return 8'd100;
      return DW'(10 + h + v);
   endfunction

   assign light = light_f(int'(ph), int'(pv), flat_mode);

   tracker_scan_fsm #(
      .DATA_W(DW), .POS_W(PW), .H_STEPS(HS), .V_STEPS(VS), .STEP_DIV(SD), .AUTO_PERIOD(0)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .btn_l_i(bl), .btn_r_i(br), .btn_u_i(bu), .btn_d_i(bd), .btn_c_i(bc),
      .light_i(light), .light_vld_i(lvld),
      .servo_l_o(sl), .servo_r_o(sr), .servo_u_o(su), .servo_d_o(sdn),
      .pos_h_o(ph), .pos_v_o(pv), .max_h_o(mh), .max_v_o(mv), .max_val_o(mval),
      .stat_o(stat), .busy_o(busy), .done_o(done)
   );

   tracker_scan_fsm #(
      .DATA_W(DW), .POS_W(PW), .H_STEPS(HS), .V_STEPS(VS), .STEP_DIV(SD), .AUTO_PERIOD(10)
   ) dut_a (
      .clk_i(clk), .rst_n_i(a_rst_n),
      .btn_l_i(1'b0), .btn_r_i(1'b0), .btn_u_i(a_bu), .btn_d_i(1'b0), .btn_c_i(1'b0),
      .light_i(light), .light_vld_i(lvld),
      .servo_l_o(a_sl), .servo_r_o(a_sr), .servo_u_o(a_su), .servo_d_o(a_sd),
      .pos_h_o(a_ph), .pos_v_o(a_pv), .max_h_o(a_mh), .max_v_o(a_mv), .max_val_o(a_mval),
      .stat_o(a_stat), .busy_o(a_busy), .done_o(a_done)
   );

   typedef struct packed {
      logic [3:0]    s;
      logic [PW-1:0] h;
      logic [PW-1:0] v;
   } sb_t;

   typedef struct {
      logic       l, r, u, d;
      logic [3:0] s;
      int         h, v;
   } vec_t;

   sb_t sbq[$];
   int  stamps[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;
   int  done_cnt = 0;
   int  exp_mh, exp_mv, exp_mval;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [3:0] s, input int h, input int v);
      sb_t e;
      e.s = s;
      e.h = PW'(h);
      e.v = PW'(v);
      sbq.push_back(e);
   endtask

   // Every strobe cycle is matched against the oldest expected step.
   always @(negedge clk) begin
      sb_t e;
      if (done) done_cnt++;
      if (sl | sr | su | sdn) begin
         stamps.push_back(cyc);
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=%b required=none h=%0d v=%0d",
                     {sl, sr, su, sdn}, ph, pv);
         end else begin
            e = sbq.pop_front();
            chk("strobe_dir", int'({sl, sr, su, sdn}), int'(e.s));
            chk("strobe_pos_h", int'(ph), int'(e.h));
            chk("strobe_pos_v", int'(pv), int'(e.v));
         end
      end
   end

   task automatic apply(input logic l, input logic r, input logic u, input logic d,
                        input logic [3:0] es, input int eh, input int ev);
      bl = l; br = r; bu = u; bd = d;
      if (es != S_0) push(es, eh, ev);
      repeat (SD) @(posedge clk);
      @(negedge clk);
      #1;
      bl = 1'b0; br = 1'b0; bu = 1'b0; bd = 1'b0;
      chk("vec_pos_h", int'(ph), eh);
      chk("vec_pos_v", int'(pv), ev);
      chk("vec_sb_empty", sbq.size(), 0);
   endtask

   task automatic wait_stat(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (int'(stat) != target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(stat), target);
   endtask

   task automatic pulse_c();
      bc = 1'b1;
      @(posedge clk);
      #1;
      bc = 1'b0;
      @(negedge clk);
   endtask

   // Reference walk of a scan; phase_lim 2 stops after H home, 1 after V home.
   task automatic model_scan(input int h0, input int v0, input logic flat, input int phase_lim);
      int h, v, best, bh, bv, val;
      h = h0;
      while (h > 0) begin h--; push(S_L, h, v0); end
      if (phase_lim == 2) return;
      best = 0; bh = 0;
      for (int i = 0; i < HS; i++) begin
         val = int'(light_f(i, v0, flat));
         if (val > best) begin best = val; bh = i; end
         if (i < HS - 1) push(S_R, i + 1, v0);
      end
      h = HS - 1;
      while (h > bh) begin h--; push(S_L, h, v0); end
      v = v0;
      while (v > 0) begin v--; push(S_D, bh, v); end
      if (phase_lim == 1) return;
      best = 0; bv = 0;
      for (int i = 0; i < VS; i++) begin
         val = int'(light_f(bh, i, flat));
         if (val > best) begin best = val; bv = i; end
         if (i < VS - 1) push(S_U, bh, i + 1);
      end
      v = VS - 1;
      while (v > bv) begin v--; push(S_D, bh, v); end
      exp_mh = bh; exp_mv = bv; exp_mval = best;
   endtask

   task automatic run_scan(input int h0, input int v0, input logic flat, input string tag);
      int d0;
      flat_mode = flat;
      d0 = done_cnt;
      model_scan(h0, v0, flat, 0);
      #1;
      pulse_c();
      chk({tag, "_start_stat"}, int'(stat), 1);
      chk({tag, "_start_busy"}, int'(busy), 1);
      wait_stat(0, 600, {tag, "_end_stat"});
      @(negedge clk);
      #1;
      chk({tag, "_done_once"}, done_cnt - d0, 1);
      chk({tag, "_max_h"}, int'(mh), exp_mh);
      chk({tag, "_max_v"}, int'(mv), exp_mv);
      chk({tag, "_max_val"}, int'(mval), exp_mval);
      chk({tag, "_pos_h"}, int'(ph), exp_mh);
      chk({tag, "_pos_v"}, int'(pv), exp_mv);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_sb_empty"}, sbq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[13];
      int   d0;

      vecs[0]  = '{l:1, r:1, u:0, d:0, s:S_0,       h:3, v:0};
      vecs[1]  = '{l:1, r:0, u:0, d:0, s:S_L,       h:2, v:0};
      vecs[2]  = '{l:0, r:1, u:0, d:0, s:S_R,       h:3, v:0};
      vecs[3]  = '{l:0, r:0, u:1, d:0, s:S_U,       h:3, v:1};
      vecs[4]  = '{l:0, r:0, u:1, d:1, s:S_0,       h:3, v:1};
      vecs[5]  = '{l:0, r:0, u:1, d:0, s:S_U,       h:3, v:2};
      vecs[6]  = '{l:0, r:0, u:1, d:0, s:S_U,       h:3, v:3};
      vecs[7]  = '{l:0, r:0, u:1, d:0, s:S_0,       h:3, v:3};
      vecs[8]  = '{l:0, r:0, u:0, d:1, s:S_D,       h:3, v:2};
      vecs[9]  = '{l:0, r:1, u:1, d:0, s:S_R | S_U, h:4, v:3};
      vecs[10] = '{l:1, r:0, u:0, d:1, s:S_L | S_D, h:3, v:2};
      vecs[11] = '{l:0, r:0, u:0, d:1, s:S_D,       h:3, v:1};
      vecs[12] = '{l:0, r:0, u:0, d:0, s:S_0,       h:3, v:1};

      rst_n = 1'b0; a_rst_n = 1'b0; a_bu = 1'b0;
      bl = 1'b0; br = 1'b0; bu = 1'b0; bd = 1'b0; bc = 1'b0;
      lvld = 1'b1; flat_mode = 1'b0;
      exp_mh = 0; exp_mv = 0; exp_mval = 0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_stat", int'(stat), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pos", int'({ph, pv}), 0);
      chk("rst_max", int'({mh, mv, mval}), 0);
      chk("rst_strobes", int'({sl, sr, su, sdn}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      apply(1'b1, 1'b0, 1'b0, 1'b0, S_0, 0, 0);

      // Held jog: one step per tick, STEP_DIV cycles apart.
      stamps.delete();
      push(S_R, 1, 0); push(S_R, 2, 0); push(S_R, 3, 0);
      br = 1'b1;
      repeat (3 * SD) @(posedge clk);
      @(negedge clk);
      #1;
      br = 1'b0;
      chk("hold_r_pulses", stamps.size(), 3);
      if (stamps.size() == 3) begin
         chk("hold_r_gap1", stamps[1] - stamps[0], SD);
         chk("hold_r_gap2", stamps[2] - stamps[1], SD);
      end
      chk("hold_r_pos_h", int'(ph), 3);

      for (int i = 0; i < 13; i++)
         apply(vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, vecs[i].s, vecs[i].h, vecs[i].v);

      run_scan(3, 1, 1'b0, "peak");
      run_scan(5, 2, 1'b1, "flat");

      // Abort right after V_SWEEP entry, before its first step.
      flat_mode = 1'b0;
      d0 = done_cnt;
      model_scan(0, 0, 1'b0, 1);
      pulse_c();
      wait_stat(5, 600, "abort_reach_vsweep");
      #1;
      pulse_c();
      chk("abort_stat", int'(stat), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_pos_h", int'(ph), 5);
      chk("abort_pos_v", int'(pv), 0);
      repeat (3 * SD) @(negedge clk);
      #1;
      chk("abort_no_done", done_cnt - d0, 0);
      chk("abort_max_h", int'(mh), 0);
      chk("abort_max_v", int'(mv), 0);
      chk("abort_max_val", int'(mval), 50);
      chk("abort_sb_empty", sbq.size(), 0);

      // Asynchronous reset while sweeping.
      model_scan(5, 0, 1'b0, 2);
      #1;
      pulse_c();
      wait_stat(2, 400, "rst_reach_hsweep");
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_stat", int'(stat), 0);
      chk("midrst_pos_h", int'(ph), 0);
      chk("midrst_strobes", int'({sl, sr, su, sdn}), 0);
      chk("midrst_max", int'({mh, mv, mval}), 0);
      chk("midrst_sb_empty", sbq.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Auto rescan: fires on the 10th idle tick after reset.
      @(negedge clk);
      a_rst_n = 1'b1;
      repeat (39) @(posedge clk);
      @(negedge clk);
      chk("auto_before_10th", int'(a_stat), 0);
      @(posedge clk);
      @(negedge clk);
      chk("auto_after_10th", int'(a_stat), 1);

      // A jog at tick 6 restarts the idle count.
      a_rst_n = 1'b0;
      @(negedge clk);
      a_rst_n = 1'b1;
      repeat (23) @(posedge clk);
      @(negedge clk);
      a_bu = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_bu = 1'b0;
      chk("auto_jog_pos_v", int'(a_pv), 1);
      repeat (39) @(posedge clk);
      @(negedge clk);
      chk("auto_restart_before", int'(a_stat), 0);
      @(posedge clk);
      @(negedge clk);
      chk("auto_restart_fire", int'(a_stat), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
